fpu_result_responder: RTL and testbench
=======================================

FPU_RESULT_RESPONDER -- requirements
Module: fpu_result_responder

Interface
REQ-001 Parameter DATA_W, default 64, result operand width in bits (32 or 64 only).
REQ-002 Parameter DEPTH, default 4, result buffer entries (power of two, 2..16).
REQ-003 Parameter TAG_W, default 4, operation tag width.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 res_valid  input  1  FPU datapath presents a completed result.
REQ-007 res_ready  output  1  responder can accept a result this cycle.
REQ-008 res_data  input  DATA_W  result value, IEEE-754.
REQ-009 res_flags  input  5  exception flags {NV,DZ,OF,UF,NX}, bit 4 = NV.
REQ-010 res_tag  input  TAG_W  tag of the originating operation.
REQ-011 out_valid  output  1  result available on the output agent interface.
REQ-012 out_ready  input  1  output agent consumes the result.
REQ-013 out_data  output  DATA_W  buffered result value.
REQ-014 out_flags  output  5  buffered exception flags.
REQ-015 out_tag  output  TAG_W  buffered tag.
REQ-016 sticky_flags  output  5  accumulated exception flags since last clear.
REQ-017 flags_clr  input  1  clear sticky_flags.
REQ-018 overflow_err  output  1  pulse: res_valid seen while res_ready low.

Function
REQ-019 Push when res_valid && res_ready; pop when out_valid && out_ready; FIFO order preserved.
REQ-020 res_ready SHALL equal (count != DEPTH), driven from registered count, no combinational path from out_ready.
REQ-021 Latency: a result pushed into an empty buffer SHALL appear on out_valid the next cycle; no same-cycle bypass.
REQ-022 out_valid SHALL be (count != 0); out_data/out_flags/out_tag SHALL stay stable while out_valid && !out_ready.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both take effect.
REQ-024 When full, push is refused even if pop occurs the same cycle; res_ready rises the cycle after the pop.
REQ-025 Pointers SHALL wrap modulo DEPTH; count width is clog2(DEPTH)+1.
REQ-026 sticky_flags SHALL OR in out_flags on each pop.
REQ-027 flags_clr with a simultaneous pop: sticky_flags SHALL become exactly the popped flags.
REQ-028 overflow_err SHALL be a one-cycle registered pulse the cycle after res_valid && !res_ready; the offending result is dropped.

Reset
REQ-029 With rst high at a clk edge: count, pointers, sticky_flags, overflow_err cleared; out_valid = 0, res_ready = 1 the following cycle.
REQ-030 Reset mid-operation SHALL discard all buffered results; out_data/out_flags/out_tag read 0 after reset until the first push.

Configuration
REQ-031 Macro FPU_RESULT_NAN_CANON_EN: when defined, any pushed res_data that is a NaN SHALL be stored as the canonical quiet NaN (0x7FF8_0000_0000_0000 for DATA_W=64, 0x7FC0_0000 for 32); flags and tag unchanged.
REQ-032 Without FPU_RESULT_NAN_CANON_EN, res_data SHALL be stored bit-exact.

Structure
REQ-033 Package fpu_result_pkg SHALL hold the flag bit-index constants, the result struct typedef (data, flags, tag), and the canonical-NaN constants.
REQ-034 Storage SHALL be a sub-module fpu_result_fifo (sync FIFO, parameterised width/depth); the top holds handshake, sticky flags, overflow detection, and NaN canonicalisation.

Verification
REQ-035 Reset, then push 0x3FF0_0000_0000_0000 flags 0 tag 3 with out_ready=1 -> out_valid on the next cycle with same data/tag; out_valid low on the following cycle.
REQ-036 out_ready=0, push 5 results with DEPTH=4 -> res_ready low after 4th; overflow_err pulses once; release out_ready -> exactly the first 4 results emerge in order.
REQ-037 Push flags 5'b00001 then 5'b10000, drain -> sticky_flags = 5'b10001; assert flags_clr together with a pop carrying 5'b00100 -> sticky_flags = 5'b00100.
REQ-038 Sustained push and pop every cycle at count=2 for 20 cycles -> count stays 2, 20 results out in order, pointers wrap without loss.
REQ-039 Push NaN 0xFFF4_0000_0000_0001: with FPU_RESULT_NAN_CANON_EN -> out_data 0x7FF8_0000_0000_0000; without it -> 0xFFF4_0000_0000_0001.
REQ-040 Fill 3 entries, assert rst for one cycle -> out_valid 0, res_ready 1, sticky_flags 0, no stale results emerge afterwards.

Source files
------------

// File: rtl/fpu_result_pkg.sv
// Shared types and constants for the FPU result responder.
// Flag bit positions, result bundle layout and canonical quiet NaNs.
package fpu_result_pkg;

  localparam int FLAGS_W = 5;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_TAG_W  = 16;

  localparam logic [63:0] CNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] CNAN32 = 32'h7FC0_0000;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic [FLAGS_W-1:0]    flags;
    logic [MAX_TAG_W-1:0]  tag;
  } fpu_result_t;

  // Exponent all ones with a non-zero mantissa.
  function automatic logic is_nan64(
    input logic [63:0] d
  );
    return (&d[62:52]) && (|d[51:0]);
  endfunction

  function automatic logic is_nan32(
    input logic [31:0] d
  );
    return (&d[30:23]) && (|d[22:0]);
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous FIFO holding buffered FPU results.
// Storage is cleared on reset so the read port shows zero until written.
module fpu_result_fifo
  import fpu_result_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next pointers and occupancy; pointers wrap by natural overflow.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_d = rd_q + PTR_W'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, wiped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fpu_result_responder.sv
// FPU result responder: buffers results, tracks sticky flags, flags overflow.
// Optional NaN canonicalisation: define FPU_RESULT_NAN_CANON_EN.
module fpu_result_responder
  import fpu_result_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [DATA_W-1:0]  res_data,
  input  logic [FLAGS_W-1:0] res_flags,
  input  logic [TAG_W-1:0]   res_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [TAG_W-1:0]   out_tag,
  output logic [FLAGS_W-1:0] sticky_flags,
  input  logic               flags_clr,
  output logic               overflow_err
);

  localparam int ENT_W = DATA_W + FLAGS_W + TAG_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  store_data;
  logic [ENT_W-1:0]   wdata;
  logic [ENT_W-1:0]   rdata;
  logic [FLAGS_W-1:0] sticky_q, sticky_d;
  logic               ovf_q, ovf_d;

  // Handshake derives only from the registered count.
  assign res_ready = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = res_valid & res_ready;
  assign pop       = out_valid & out_ready;

`ifdef FPU_RESULT_NAN_CANON_EN
  if (DATA_W == 64) begin : g_canon64
    assign store_data = is_nan64(res_data) ? CNAN64 : res_data;
  end else begin : g_canon32
    assign store_data = is_nan32(res_data) ? CNAN32 : res_data;
  end
`else
  assign store_data = res_data;
`endif

  assign wdata = {store_data, res_flags, res_tag};

  fpu_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .count_o (count)
  );

  assign out_data  = rdata[ENT_W-1 -: DATA_W];
  assign out_flags = rdata[TAG_W +: FLAGS_W];
  assign out_tag   = rdata[TAG_W-1:0];

  // Sticky accumulation; a clear with a pop keeps only the popped flags.
  always_comb begin
    sticky_d = sticky_q;
    ovf_d    = res_valid & ~res_ready;
    if (pop) begin
      sticky_d = flags_clr ? out_flags : (sticky_q | out_flags);
    end else if (flags_clr) begin
      sticky_d = '0;
    end
  end

  // Sticky flags and overflow pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fpu_result_responder.sv
// Self-checking bench for fpu_result_responder (DATA_W=64, DEPTH=4).
// Queue model stepped each clock, compared on every falling edge.
module tb_fpu_result_responder;

  localparam int DW = 64;
  localparam int DP = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [DW-1:0] res_data = '0;
  logic [4:0]    res_flags = '0;
  logic [TW-1:0] res_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [4:0]    out_flags;
  logic [TW-1:0] out_tag;
  logic [4:0]    sticky_flags;
  logic          flags_clr = 1'b0;
  logic          overflow_err;

  fpu_result_responder #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .TAG_W  (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flags    (res_flags),
    .res_tag      (res_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  f;
    logic [3:0]  t;
  } ent_t;

  ent_t       q[$];
  logic [4:0] m_sticky = '0;
  logic       m_ovf = 1'b0;
  bit         m_fresh = 1'b1;
  bit         chk_en = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] canon(input logic [63:0] d);
`ifdef FPU_RESULT_NAN_CANON_EN
    if (d[62:52] == 11'h7FF && d[51:0] != 52'd0) begin
      return 64'h7FF8_0000_0000_0000;
    end
`endif
    return d;
  endfunction

  // Model of one clock edge, from the inputs held since the last negedge.
  task automatic model_step();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (rst) begin
      q.delete();
      m_sticky = '0;
      m_ovf    = 1'b0;
      m_fresh  = 1'b1;
      chk_en   = 1'b1;
      return;
    end
    do_pop  = (q.size() != 0) && out_ready;
    do_push = res_valid && (q.size() != DP);
    m_ovf   = res_valid && (q.size() == DP);
    if (do_pop) begin
      m_sticky = flags_clr ? q[0].f : (m_sticky | q[0].f);
      void'(q.pop_front());
    end else if (flags_clr) begin
      m_sticky = '0;
    end
    if (do_push) begin
      e.d = canon(res_data);
      e.f = res_flags;
      e.t = res_tag;
      q.push_back(e);
      m_fresh = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("res_ready", res_ready, q.size() != DP);
      chk("overflow_err", overflow_err, m_ovf);
      chk("sticky_flags", sticky_flags, m_sticky);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_flags", out_flags, q[0].f);
        chk("out_tag", out_tag, q[0].t);
      end else if (m_fresh) begin
        chk("out_data_zero", out_data, 0);
        chk("out_flags_zero", out_flags, 0);
        chk("out_tag_zero", out_tag, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("lit_rst_valid", out_valid, 0);
    chk("lit_rst_ready", res_ready, 1);
    chk("lit_rst_sticky", sticky_flags, 0);

    // Single result through an empty buffer.
    res_valid = 1'b1;
    res_data  = 64'h3FF0_0000_0000_0000;
    res_flags = 5'b00000;
    res_tag   = 4'd3;
    out_ready = 1'b1;
    cyc();
    res_valid = 1'b0;
    chk("lit_first_valid", out_valid, 1);
    chk("lit_first_data", out_data, 64'h3FF0_0000_0000_0000);
    chk("lit_first_tag", out_tag, 3);
    cyc();
    chk("lit_first_gone", out_valid, 0);

    // Overfill with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1;
      res_data  = 64'h4000_0000_0000_0000 + 64'(i);
      res_tag   = 4'(i);
      cyc();
      if (i == 3) chk("lit_full_ready", res_ready, 0);
    end
    chk("lit_ovf_pulse", overflow_err, 1);
    res_valid = 1'b0;
    cyc();
    chk("lit_ovf_clear", overflow_err, 0);
    chk("lit_head_data", out_data, 64'h4000_0000_0000_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("lit_drain_tag", out_tag, 4'(i));
      cyc();
    end
    chk("lit_drained", out_valid, 0);

    // Sticky accumulation and clear-with-pop.
    res_valid = 1'b1;
    res_flags = 5'b00001;
    res_tag   = 4'd1;
    cyc();
    res_flags = 5'b10000;
    res_tag   = 4'd2;
    cyc();
    res_valid = 1'b0;
    cyc();
    cyc();
    chk("lit_sticky_or", sticky_flags, 5'b10001);
    out_ready = 1'b0;
    res_valid = 1'b1;
    res_flags = 5'b00100;
    cyc();
    res_valid = 1'b0;
    out_ready = 1'b1;
    flags_clr = 1'b1;
    cyc();
    flags_clr = 1'b0;
    res_flags = 5'b00000;
    chk("lit_sticky_clr", sticky_flags, 5'b00100);

    // Sustained push and pop at two entries.
    out_ready = 1'b0;
    res_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      res_data = 64'h5000_0000_0000_0000 + 64'(i);
      res_tag  = 4'(i);
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 22; i++) begin
      res_data = 64'h5000_0000_0000_0000 + 64'(i);
      res_tag  = 4'(i);
      cyc();
    end
    res_valid = 1'b0;
    chk("lit_stream_valid", out_valid, 1);
    chk("lit_stream_tag", out_tag, 4'(20));
    cyc();
    cyc();
    chk("lit_stream_empty", out_valid, 0);

    // NaN storage.
    out_ready = 1'b0;
    res_valid = 1'b1;
    res_data  = 64'hFFF4_0000_0000_0001;
    res_tag   = 4'd9;
    cyc();
    res_valid = 1'b0;
`ifdef FPU_RESULT_NAN_CANON_EN
    chk("lit_nan", out_data, 64'h7FF8_0000_0000_0000);
`else
    chk("lit_nan", out_data, 64'hFFF4_0000_0000_0001);
`endif

    // Reset with three buffered entries.
    res_valid = 1'b1;
    res_flags = 5'b01000;
    for (int i = 0; i < 2; i++) begin
      res_data = 64'h6000_0000_0000_0000 + 64'(i);
      cyc();
    end
    res_valid = 1'b0;
    res_flags = 5'b00000;
    out_ready = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("lit_mid_rst_valid", out_valid, 0);
    chk("lit_mid_rst_ready", res_ready, 1);
    chk("lit_mid_rst_sticky", sticky_flags, 0);
    chk("lit_mid_rst_data", out_data, 0);
    cyc();
    cyc();
    chk("lit_no_stale", out_valid, 0);

    // Full buffer: pop and push together, push refused.
    out_ready = 1'b0;
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_data = 64'h7000_0000_0000_0000 + 64'(i);
      res_tag  = 4'(i);
      cyc();
    end
    res_data  = 64'h7000_0000_0000_00FF;
    res_tag   = 4'd15;
    out_ready = 1'b1;
    cyc();
    res_valid = 1'b0;
    chk("lit_full_pop_ovf", overflow_err, 1);
    chk("lit_full_pop_ready", res_ready, 1);
    chk("lit_full_pop_head", out_tag, 1);
    for (int i = 0; i < 4; i++) cyc();
    chk("lit_final_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
